// File: rtl/onchip_mem_test_pkg.sv
// Shared types and the address-dependent test pattern for the on-chip memory self-test master.
package onchip_mem_test_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN,
    DONE
  } state_t;

  // Widest data/address the pattern helper supports; callers cast down to their own widths.
  localparam int PAT_W = 64;

  function automatic logic [PAT_W-1:0] pattern(input logic [PAT_W-1:0] seed,
                                               input logic [PAT_W-1:0] addr,
                                               input int               shift);
    return seed ^ addr ^ (addr << shift);
  endfunction

endpackage

// File: rtl/onchip_mem_test_master_if.sv
// Avalon-MM word-addressed bus between the self-test master and the on-chip memory responder.
interface onchip_mem_test_master_if #(
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   address;
  logic [DATA_WIDTH/8-1:0] byteenable;
  logic                    chipselect;
  logic                    write;
  logic [DATA_WIDTH-1:0]   writedata;
  logic                    read;
  logic [DATA_WIDTH-1:0]   readdata;
  logic                    waitrequest;

  modport master (
    output address, byteenable, chipselect, write, writedata, read,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, byteenable, chipselect, write, writedata, read,
    output readdata, waitrequest
  );
endinterface

// File: rtl/avm_rd_latency_pipe.sv
// Delay line that carries {valid, addr} of each accepted read until its data returns.
module avm_rd_latency_pipe #(
  parameter int LATENCY    = 1,
  parameter int ADDR_WIDTH = 17
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  output logic                  out_valid,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  empty
);

  logic [LATENCY-1:0]    valid_q;
  logic [ADDR_WIDTH-1:0] addr_q [LATENCY];

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= in_valid;
      for (int i = 1; i < LATENCY; i++) valid_q[i] <= valid_q[i-1];
    end
  end

  // NOTE: the address stages are qualified by valid_q, so they carry no reset and stay plain flops.
  always_ff @(posedge clk) begin
    addr_q[0] <= in_addr;
    for (int i = 1; i < LATENCY; i++) addr_q[i] <= addr_q[i-1];
  end

  assign out_valid = valid_q[LATENCY-1];
  assign out_addr  = addr_q[LATENCY-1];
  assign empty     = ~|valid_q;

endmodule

// File: rtl/onchip_mem_test_master.sv
// Avalon-MM BIST master: writes a seeded pattern to every word, reads it back, counts mismatches.
module onchip_mem_test_master
  import onchip_mem_test_pkg::*;
#(
  parameter int ADDR_WIDTH   = 17,
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_WORDS    = 98304,
  parameter int READ_LATENCY = 1,
  parameter int ERR_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [DATA_WIDTH-1:0]   seed,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [ERR_WIDTH-1:0]    err_count,
  output logic [ADDR_WIDTH-1:0]   first_err_addr,
  onchip_mem_test_master_if.master avm
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] seed_q;
  logic                  wr_q;
  logic                  rd_q;
  logic                  accept;
  logic                  pipe_valid;
  logic [ADDR_WIDTH-1:0] pipe_addr;
  logic                  pipe_empty;
  logic                  mismatch;

  function automatic logic [DATA_WIDTH-1:0] pat(input logic [DATA_WIDTH-1:0] s,
                                                input logic [ADDR_WIDTH-1:0] a);
    return DATA_WIDTH'(pattern(PAT_W'(s), PAT_W'(a), DATA_WIDTH - ADDR_WIDTH));
  endfunction

  assign accept   = (wr_q | rd_q) & ~avm.waitrequest;
  assign mismatch = pipe_valid && (avm.readdata != pat(seed_q, pipe_addr));

  avm_rd_latency_pipe #(
    .LATENCY    (READ_LATENCY),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_rd_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (rd_q & ~avm.waitrequest),
    .in_addr   (addr),
    .out_valid (pipe_valid),
    .out_addr  (pipe_addr),
    .empty     (pipe_empty)
  );

  assign avm.address    = addr;
  assign avm.write      = wr_q;
  assign avm.read       = rd_q;
  assign avm.chipselect = wr_q | rd_q;
  assign avm.byteenable = {(DATA_WIDTH/8){wr_q | rd_q}};
  assign avm.writedata  = wr_q ? pat(seed_q, addr) : '0;

  // NOTE: non-blocking assignments everywhere here; every branch sees pre-edge values, and a later
  // assignment to the same register in this block (the IDLE clear of err_count) wins over an earlier one.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      addr           <= '0;
      seed_q         <= '0;
      wr_q           <= 1'b0;
      rd_q           <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
    end else begin
      done <= 1'b0;

      // err_count still at zero means this is the first mismatch of the run.
      if (mismatch) begin
        if (err_count == '0) first_err_addr <= pipe_addr;
        if (err_count != '1) err_count <= err_count + ERR_WIDTH'(1);
      end

      unique case (state)
        IDLE: begin
          if (start) begin
            seed_q         <= seed;
            err_count      <= '0;
            first_err_addr <= '0;
            pass           <= 1'b0;
            addr           <= '0;
            wr_q           <= 1'b1;
            busy           <= 1'b1;
            state          <= WRITE;
          end
        end
        WRITE: begin
          if (accept) begin
            if (addr == LAST_ADDR) begin
              addr  <= '0;
              wr_q  <= 1'b0;
              rd_q  <= 1'b1;
              state <= READ;
            end else begin
              addr <= addr + ADDR_WIDTH'(1);
            end
          end
        end
        READ: begin
          if (accept) begin
            if (addr == LAST_ADDR) begin
              addr  <= '0;
              rd_q  <= 1'b0;
              state <= DRAIN;
            end else begin
              addr <= addr + ADDR_WIDTH'(1);
            end
          end
        end
        DRAIN: begin
          // An empty pipe means the last compare already landed in err_count.
          if (pipe_empty) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_count == '0);
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
